// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock with a registered carry.
// Optional subtract mode (input sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             sub_mode;

    logic             accept;
    logic             last_bit;
    logic             bit_s;
    logic             carry_next;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sub_q <= 1'b0;
        else     sub_q <= sub_d;
    end

    always_comb begin
        sub_d = sub_q;
        if (accept) sub_d = sub;
    end

    assign sub_mode = sub_q;
`else
    assign sub_mode = 1'b0;
`endif

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // One full adder / full subtractor cell; carry_q doubles as the borrow in subtract mode.
    assign bit_s      = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_next = sub_mode
                      ? ((~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & carry_q))
                      : ((a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0])));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath: result bits shift into the MSB of the A register as operand bits leave its LSB.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = {bit_s, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = carry_next;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                sum_d  = {bit_s, a_q[WIDTH-1:1]};
                cout_d = carry_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed handshake cases plus random operands
// against an arithmetic reference; subtract cases run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         ready, busy, done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, 64'(ready), 64'd1);
    endtask

    // Full transaction from IDLE; operand inputs are scrambled after acceptance.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic subv);
        logic [W:0]   ref_full;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        int           n;
        bit           held_ok;
        bit           onehot_ok;

        if (subv) begin
            exp_sum  = av - bv;
            exp_cout = (av < bv);
        end else begin
            ref_full = {1'b0, av} + {1'b0, bv};
            exp_sum  = ref_full[W-1:0];
            exp_cout = ref_full[W];
        end

        wait_ready(tag);
        prev_sum  = sum;
        prev_cout = cout;
        start = 1'b1;
        a     = av;
        b     = bv;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = subv;
`endif
        tick();
        start     = 1'b0;
        n         = 0;
        held_ok   = 1'b1;
        onehot_ok = 1'b1;
        while (busy && n < 100) begin
            a = W'($urandom);
            b = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
            if (sum !== prev_sum || cout !== prev_cout) held_ok = 1'b0;
            if ({ready, busy, done} != 3'b010) onehot_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(W));
        check({tag, "_result_held"}, 64'(held_ok), 64'd1);
        check({tag, "_onehot"}, 64'(onehot_ok), 64'd1);
        check({tag, "_done"}, {61'd0, ready, busy, done}, 64'b001);
        check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        tick();
        check({tag, "_ready_after"}, {61'd0, ready, busy, done}, 64'b100);
    endtask

    initial begin
        int           n;
        int           dones;
        int           done_at[$];
        bit           stable_ok;
        logic [W-1:0] ra, rb;
        logic         rs;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) tick();
        check("reset_flags", {61'd0, ready, busy, done}, 64'b100);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        tick();

        do_op("add_3c_05", 8'h3C, 8'h05, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        do_op("add_80_80", 8'h80, 8'h80, 1'b0);
        do_op("add_00_00", 8'h00, 8'h00, 1'b0);

        // start during RUN and during DONE must be ignored
        wait_ready("ign");
        start = 1'b1; a = 8'h10; b = 8'h20;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; a = 8'hAA; b = 8'h55;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check("ign_done_seen", 64'(done), 64'd1);
        check("ign_sum", 64'(sum), 64'h30);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        tick();
        start = 1'b0;
        check("ign_idle_after_done", {61'd0, ready, busy, done}, 64'b100);
        dones = 0;
        stable_ok = 1'b1;
        repeat (15) begin
            tick();
            if (done) dones++;
            if (sum !== 8'h30) stable_ok = 1'b0;
        end
        check("ign_no_second_done", 64'(dones), 64'd0);
        check("ign_sum_stable", 64'(stable_ok), 64'd1);

        // asynchronous reset in the middle of RUN
        wait_ready("rst");
        start = 1'b1; a = 8'h7F; b = 8'h01;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("rst_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_flags", {61'd0, ready, busy, done}, 64'b100);
        check("rst_async_sum", 64'(sum), 64'd0);
        check("rst_async_cout", 64'(cout), 64'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        do_op("rst_after_7f_01", 8'h7F, 8'h01, 1'b0);

        // start held high: completions every W+2 cycles
        wait_ready("b2b");
        start = 1'b1; a = 8'h01; b = 8'h02;
        stable_ok = 1'b1;
        for (int c = 0; c < 46; c++) begin
            tick();
            if (done) begin
                done_at.push_back(c);
                if (sum !== 8'h03) stable_ok = 1'b0;
            end else if (done_at.size() > 0 && sum !== 8'h03) begin
                stable_ok = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(done_at.size() >= 3), 64'd1);
        for (int i = 1; i < done_at.size(); i++)
            check("b2b_interval", 64'(done_at[i] - done_at[i-1]), 64'(W + 2));
        check("b2b_sum_stable", 64'(stable_ok), 64'd1);

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_05_07", 8'h05, 8'h07, 1'b1);
        do_op("sub_09_04", 8'h09, 8'h04, 1'b1);
        do_op("sub_00_00", 8'h00, 8'h00, 1'b1);
        do_op("sub_mode_add", 8'hF0, 8'h20, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op("rand", ra, rb, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
